// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN_DEFAULT      default PC width
//   RESET_PC_DEFAULT  default reset fetch address
//   INSTR_W           instruction word width
//   fetch_entry_t     {pc, instr} queue entry at the default PC width
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT     = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0040_0000;
    localparam int unsigned INSTR_W          = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid  head entry valid (fetch -> decode)
//   out_instr  head instruction (fetch -> decode)
//   out_pc     PC of head instruction (fetch -> decode)
//   out_ready  decode accepts the head entry (decode -> fetch)
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) ();

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used as the fetch queue.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   flush         empties the queue (same effect as reset on occupancy)
//   push, wdata   enqueue request and data; ignored when full unless pop
//   pop           dequeue request; ignored when empty
//   rdata         head entry (stale when empty)
//   full, empty   occupancy flags
module fetch_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [31:0]
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rdata    = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, word-addressed instruction memory with a
// program-load write port, and a fetch queue feeding decode over a valid/ready handshake.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   imem_we/waddr/wdata program-load write port (memory is not cleared by reset)
//   redirect_valid/pc   redirect fetch; flushes the queue, highest priority
//   dec                 fetch_if master: out_valid/out_instr/out_pc/out_ready
//   fetch_pc            address of the next fetch
//   fetch_fault         misaligned-redirect fault
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a misaligned redirect
// parks fetch in a FAULT state until an aligned redirect or reset. When undefined, the
// redirect target is aligned down to a word and fetch_fault is always 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter int unsigned     IMEM_DEPTH = 256,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INSTR_W-1:0]            imem_wdata,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    fetch_if.master                       dec,
    output logic [XLEN-1:0]               fetch_pc,
    output logic                          fetch_fault
);

    localparam int unsigned IW = $clog2(IMEM_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [XLEN-1:0]    fetch_pc_q;
    logic [XLEN-1:0]    redirect_target;
    logic [IW-1:0]      fetch_index;
    logic               fault;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    entry_t             push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic StRun   = 1'b0;
    localparam logic StFault = 1'b1;

    logic state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
        end else if (redirect_valid) begin
            state_q <= (redirect_pc[1:0] != 2'b00) ? StFault : StRun;
        end
    end

    assign fault           = (state_q == StFault);
    assign redirect_target = redirect_pc;
`else
    assign fault           = 1'b0;
    assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

    // Program load; a write to the index being fetched shows up on the next cycle.
    always_ff @(posedge clock) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        fetch_index      = fetch_pc_q[IW+1:2];
        push_entry.pc    = fetch_pc_q;
        push_entry.instr = imem[fetch_index];
        // Redirect discards both the head pop and the fetch of this cycle.
        pop  = !fifo_empty && dec.out_ready && !redirect_valid;
        push = !redirect_valid && !fault && (!fifo_full || pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
        end else if (push) begin
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields read as zero when the queue is empty.
    always_comb begin
        dec.out_valid = !fifo_empty;
        dec.out_instr = fifo_empty ? '0 : head_entry.instr;
        dec.out_pc    = fifo_empty ? '0 : head_entry.pc;
        fetch_pc      = fetch_pc_q;
        fetch_fault   = fault;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters).
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_if #(.XLEN(64)) dec ();

    fetch_unit u_dut (
        .clock          (clock),
        .reset          (reset),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec),
        .fetch_pc       (fetch_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [7:0] addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        tick();
        imem_we    = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec.out_ready  = 1'b0;

        // Program load under reset: IMEM[i] = 48 + i for i < 16, IMEM[255] = deadbeef.
        for (int i = 0; i < 16; i++) write_word(8'(i), 32'(48 + i));
        write_word(8'd255, 32'hdead_beef);
        tick();

        check_eq("rst_valid", 64'(dec.out_valid), 64'd0);
        check_eq("rst_pc", dec.out_pc, 64'd0);
        check_eq("rst_instr", 64'(dec.out_instr), 64'd0);
        check_eq("rst_fetch_pc", fetch_pc, 64'h40_0000);
        check_eq("rst_fault", 64'(fetch_fault), 64'd0);

        // Streaming with decode always ready.
        reset         = 1'b0;
        dec.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stream_valid", 64'(dec.out_valid), 64'd1);
            check_eq("stream_pc", dec.out_pc, 64'h40_0000 + 64'(4 * i));
            check_eq("stream_instr", 64'(dec.out_instr), 64'(48 + i));
        end

        // Stall: queue fills after 4 fetches and the head is held.
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        dec.out_ready = 1'b0;
        check_eq("rerst_valid", 64'(dec.out_valid), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("stall_valid", 64'(dec.out_valid), 64'd1);
        check_eq("stall_pc", dec.out_pc, 64'h40_0000);
        check_eq("stall_instr", 64'(dec.out_instr), 64'd48);
        check_eq("stall_fetch_pc", fetch_pc, 64'h40_0010);

        // Push and pop together on a full queue.
        dec.out_ready = 1'b1;
        tick();
        check_eq("fullpp_pc", dec.out_pc, 64'h40_0004);
        check_eq("fullpp_fetch_pc", fetch_pc, 64'h40_0014);

        // Redirect with a non-empty queue.
        redirect(64'h40_0020);
        check_eq("redir_valid0", 64'(dec.out_valid), 64'd0);
        check_eq("redir_fetch_pc", fetch_pc, 64'h40_0020);
        tick();
        check_eq("redir_valid1", 64'(dec.out_valid), 64'd1);
        check_eq("redir_pc", dec.out_pc, 64'h40_0020);
        check_eq("redir_instr", 64'(dec.out_instr), 64'd56);

        // Index wrap: 0x4003FC is word 255, the next PC maps back to word 0.
        redirect(64'h40_03FC);
        tick();
        check_eq("wrap_pc0", dec.out_pc, 64'h40_03FC);
        check_eq("wrap_instr0", 64'(dec.out_instr), 64'hdead_beef);
        tick();
        check_eq("wrap_pc1", dec.out_pc, 64'h40_0400);
        check_eq("wrap_instr1", 64'(dec.out_instr), 64'd48);

        // Misaligned redirect.
        redirect(64'h40_0006);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("mis_fault", 64'(fetch_fault), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mis_valid", 64'(dec.out_valid), 64'd0);
        end
        check_eq("mis_fetch_pc", fetch_pc, 64'h40_0006);
        redirect(64'h40_0000);
        check_eq("mis_clear", 64'(fetch_fault), 64'd0);
        tick();
        check_eq("mis_resume_pc", dec.out_pc, 64'h40_0000);
`else
        check_eq("mis_fault", 64'(fetch_fault), 64'd0);
        check_eq("mis_fetch_pc", fetch_pc, 64'h40_0004);
        tick();
        check_eq("mis_pc", dec.out_pc, 64'h40_0004);
        check_eq("mis_instr", 64'(dec.out_instr), 64'd49);
`endif

        // Reset with three queued entries; memory contents survive.
        dec.out_ready = 1'b0;
        redirect(64'h40_0000);
        for (int i = 0; i < 3; i++) tick();
        check_eq("q3_fetch_pc", fetch_pc, 64'h40_000C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("q3_rst_valid", 64'(dec.out_valid), 64'd0);
        check_eq("q3_rst_fetch_pc", fetch_pc, 64'h40_0000);
        dec.out_ready = 1'b1;
        tick();
        check_eq("q3_mem0", 64'(dec.out_instr), 64'd48);
        tick();
        check_eq("q3_mem1", 64'(dec.out_instr), 64'd49);

        // Write to the word being fetched in the same cycle: old data fetched.
        redirect(64'h40_0010);
        write_word(8'd4, 32'h0000_1234);
        check_eq("wcol_old", 64'(dec.out_instr), 64'd52);
        redirect(64'h40_0010);
        tick();
        check_eq("wcol_new", 64'(dec.out_instr), 64'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
